cache_arbiter: RTL and testbench

Shares the single physical-memory port between the CPU's instruction cache and data cache. Each cache issues line-sized read or write requests. The arbiter grants one requester at a time, steers its address, data and command onto the memory port, and routes the memory response back to the granted cache only. It sits between the two L1 caches and physical memory (or L2), below the pipelined datapath driven by the instruction decoder.

---
 rtl/cache_arbiter.sv | 117 +++++++++++
 tb/tb_cache_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and the D-cache; tie-break set by CACHE_ARBITER_RR_EN.
// Latency: a request sampled in IDLE drives the pmem command on the next cycle; resp follows pmem_resp combinationally.
// Backpressure: a losing or late requester holds its request until granted; each grant ends with one DONE turnaround cycle.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       i_req;
    logic       d_req;
    logic       pick_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_RR_EN
    // On a tie, hand the port to whoever did not hold it last.
    assign pick_d = d_req & (~i_req | ~last_grant);
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nxt      = D_BUSY;
                    last_grant_nxt = 1'b1;
                end else if (i_req) begin
                    state_nxt      = I_BUSY;
                    last_grant_nxt = 1'b0;
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    state_nxt = DONE;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Only the granted cache sees its command on the port or a resp back.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state)
            I_BUSY: begin
                pmem_read    = i_read;
                pmem_address = i_address;
                i_resp       = pmem_resp;
            end
            D_BUSY: begin
                pmem_read    = d_read;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_resp       = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: scripted cache requests against a fixed-latency memory model, with a grant-order scoreboard.
module tb_cache_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    typedef struct packed {
        logic              src;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    logic              mem_auto;
    int                mem_lat;
    int                mem_cnt = 0;
    logic [LINE_W-1:0] mem_line;
    logic              mem_resp_m = 1'b0;
    logic [LINE_W-1:0] mem_rdata_m = '0;
    logic              man_resp;
    logic [LINE_W-1:0] man_rdata;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   checks = 0;
    int   failures = 0;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    assign pmem_resp  = mem_auto ? mem_resp_m  : man_resp;
    assign pmem_rdata = mem_auto ? mem_rdata_m : man_rdata;

    // Memory: answers on the mem_lat-th consecutive cycle a command is held, logging what it saw.
    always @(posedge clk) begin
        #2;
        if (!rst && (pmem_read || pmem_write)) begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt == mem_lat) begin
                mem_resp_m  = 1'b1;
                mem_rdata_m = mem_line;
                obs_q.push_back(txn_t'{src: 1'b0, wr: pmem_write, addr: pmem_address, wdata: pmem_wdata});
            end else begin
                mem_resp_m  = 1'b0;
                mem_rdata_m = ~mem_line;
            end
        end else begin
            mem_cnt    = 0;
            mem_resp_m = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic pop_sb(output txn_t e, output txn_t o, output bit ok);
        ok = (exp_q.size() != 0) && (obs_q.size() != 0);
        e  = '0;
        o  = '0;
        if (ok) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        mem_auto = 1'b1; man_resp = 1'b0; man_rdata = '0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [LINE_W-1:0] pat;
        pat = {8{32'hC0FFEE11}};
        mem_auto = 1'b0; man_rdata = pat; man_resp = 1'b1;
        i_read = 1'b1; d_write = 1'b1; i_address = 32'h10; d_address = 32'h20; d_wdata = '1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
            begin failures++; $display("FAIL reset_cmd got=%b exp=0000", {pmem_read, pmem_write, i_resp, d_resp}); end
        checks++;
        if ({pmem_address, pmem_wdata} !== '0)
            begin failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", pmem_address, pmem_wdata); end
        checks++;
        if (i_rdata !== pat || d_rdata !== pat)
            begin failures++; $display("FAIL reset_rdata_pass got=%h/%h exp=%h", i_rdata, d_rdata, pat); end
        man_resp = 1'b0;
    endtask

    task automatic test_single_i();
        logic [LINE_W-1:0] line;
        logic [3:0]        ex;
        logic [ADDR_W-1:0] ea;
        txn_t e, o;
        bit ok;
        line = {32{8'hA5}};
        do_reset();
        mem_lat = 5; mem_line = line;
        i_read = 1'b1; i_address = 32'h0000_1000;
        exp_q.push_back(txn_t'{src: 1'b0, wr: 1'b0, addr: 32'h0000_1000, wdata: '0});
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            ex = {(c >= 1 && c <= 5), 1'b0, (c == 5), 1'b0};
            ea = (c >= 1 && c <= 5) ? 32'h0000_1000 : 32'h0;
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== ex)
                begin failures++; $display("FAIL single_i_cmd c=%0d got=%b exp=%b", c, {pmem_read, pmem_write, i_resp, d_resp}, ex); end
            checks++;
            if (pmem_address !== ea)
                begin failures++; $display("FAIL single_i_addr c=%0d got=%h exp=%h", c, pmem_address, ea); end
            if (i_resp) begin
                checks++;
                if (i_rdata !== line)
                    begin failures++; $display("FAIL single_i_rdata got=%h exp=%h", i_rdata, line); end
                pop_sb(e, o, ok);
                checks++;
                if (!ok || {d_resp, o.wr, o.addr, o.wdata} !== {e.src, e.wr, e.addr, e.wdata})
                    begin failures++; $display("FAIL single_i_sb ok=%0d got=%h exp=%h", ok, {d_resp, o.wr, o.addr}, {e.src, e.wr, e.addr}); end
            end
            @(posedge clk);
            #1;
            if (c == 5) i_read = 1'b0;
        end
    endtask

    task automatic test_single_dwrite();
        logic [LINE_W-1:0] wd;
        logic [3:0]        ex;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ew;
        txn_t e, o;
        bit ok;
        wd = {8{32'h1234_5678}};
        do_reset();
        mem_lat = 3; mem_line = {8{32'hDEAD_BEEF}};
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = wd;
        exp_q.push_back(txn_t'{src: 1'b1, wr: 1'b1, addr: 32'h8000_0040, wdata: wd});
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            ex = {1'b0, (c >= 1 && c <= 3), 1'b0, (c == 3)};
            ea = (c >= 1 && c <= 3) ? 32'h8000_0040 : 32'h0;
            ew = (c >= 1 && c <= 3) ? wd : '0;
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== ex)
                begin failures++; $display("FAIL dwrite_cmd c=%0d got=%b exp=%b", c, {pmem_read, pmem_write, i_resp, d_resp}, ex); end
            checks++;
            if (pmem_address !== ea || pmem_wdata !== ew)
                begin failures++; $display("FAIL dwrite_addr_wdata c=%0d got=%h/%h exp=%h/%h", c, pmem_address, pmem_wdata, ea, ew); end
            if (d_resp) begin
                pop_sb(e, o, ok);
                checks++;
                if (!ok || {d_resp, o.wr, o.addr, o.wdata} !== {e.src, e.wr, e.addr, e.wdata})
                    begin failures++; $display("FAIL dwrite_sb ok=%0d got=%h exp=%h", ok, {d_resp, o.wr, o.addr}, {e.src, e.wr, e.addr}); end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_write = 1'b0;
        end
    endtask

    // Both ask at cycle 0: D first (priority, or round-robin fresh from reset with last_grant=0),
    // then DONE and IDLE sit between d_resp and the I command.
    task automatic test_contention();
        logic [3:0]        ex;
        logic [ADDR_W-1:0] ea;
        txn_t e, o;
        bit ok;
        do_reset();
        mem_lat = 3; mem_line = {8{32'h0BAD_F00D}};
        i_read = 1'b1; i_address = 32'h2000;
        d_read = 1'b1; d_address = 32'h3000;
        exp_q.push_back(txn_t'{src: 1'b1, wr: 1'b0, addr: 32'h3000, wdata: '0});
        exp_q.push_back(txn_t'{src: 1'b0, wr: 1'b0, addr: 32'h2000, wdata: '0});
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            ex = {((c >= 1 && c <= 3) || (c >= 6 && c <= 8)), 1'b0, (c == 8), (c == 3)};
            ea = (c >= 1 && c <= 3) ? 32'h3000 : ((c >= 6 && c <= 8) ? 32'h2000 : 32'h0);
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== ex)
                begin failures++; $display("FAIL contention_cmd c=%0d got=%b exp=%b", c, {pmem_read, pmem_write, i_resp, d_resp}, ex); end
            checks++;
            if (pmem_address !== ea)
                begin failures++; $display("FAIL contention_addr c=%0d got=%h exp=%h", c, pmem_address, ea); end
            if (i_resp || d_resp) begin
                pop_sb(e, o, ok);
                checks++;
                if (!ok || {d_resp, o.wr, o.addr} !== {e.src, e.wr, e.addr})
                    begin failures++; $display("FAIL contention_sb ok=%0d got=%h exp=%h", ok, {d_resp, o.wr, o.addr}, {e.src, e.wr, e.addr}); end
            end
            @(posedge clk);
            #1;
            if (c == 3) d_read = 1'b0;
            if (c == 8) i_read = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        txn_t e, o;
        bit ok, got;
        do_reset();
        mem_lat = 2; mem_line = {8{32'h5555_AAAA}};
        i_read = 1'b1; i_address = 32'h5000;
        d_read = 1'b1; d_address = 32'h6000;
        for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARBITER_RR_EN
            exp_q.push_back(txn_t'{src: (k % 2 == 0), wr: 1'b0,
                                   addr: (k % 2 == 0) ? 32'h6000 : 32'h5000, wdata: '0});
`else
            exp_q.push_back(txn_t'{src: 1'b1, wr: 1'b0, addr: 32'h6000, wdata: '0});
`endif
        end
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                got = i_resp || d_resp;
            end
            checks++;
            if (!got) begin
                failures++; $display("FAIL b2b_timeout grant=%0d got=none exp=resp", k);
            end else begin
                pop_sb(e, o, ok);
                if (!ok || {d_resp, o.addr} !== {e.src, e.addr})
                    begin failures++; $display("FAIL b2b_order grant=%0d got=%h exp=%h", k, {d_resp, o.addr}, {e.src, e.addr}); end
            end
        end
        @(posedge clk);
        #1;
        i_read = 1'b0; d_read = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] ex;
        txn_t e, o;
        bit ok;
        do_reset();
        mem_lat = 5; mem_line = {8{32'h7777_0000}};
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {8{32'hFEED_0001}};
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (c == 2) begin
                checks++;
                if (pmem_write !== 1'b1)
                    begin failures++; $display("FAIL midrst_pre got=%b exp=1", pmem_write); end
            end
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({pmem_read, pmem_write, d_resp, pmem_address} !== '0)
            begin failures++; $display("FAIL midrst_drop got=%b%b%b %h exp=0", pmem_read, pmem_write, d_resp, pmem_address); end
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
                begin failures++; $display("FAIL midrst_quiet c=%0d got=%b exp=0000", c, {pmem_read, pmem_write, i_resp, d_resp}); end
        end
        checks++;
        if (obs_q.size() !== 0)
            begin failures++; $display("FAIL midrst_no_txn got=%0d exp=0", obs_q.size()); end
        @(posedge clk);
        #1;
        mem_lat = 2;
        d_read = 1'b1; d_address = 32'h4000;
        exp_q.push_back(txn_t'{src: 1'b1, wr: 1'b0, addr: 32'h4000, wdata: '0});
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            ex = {(c == 1 || c == 2), 1'b0, 1'b0, (c == 2)};
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== ex)
                begin failures++; $display("FAIL midrst_fresh c=%0d got=%b exp=%b", c, {pmem_read, pmem_write, i_resp, d_resp}, ex); end
            if (d_resp) begin
                pop_sb(e, o, ok);
                checks++;
                if (!ok || {o.wr, o.addr} !== {e.wr, e.addr} || d_rdata !== mem_line)
                    begin failures++; $display("FAIL midrst_sb ok=%0d got=%h exp=%h", ok, {o.wr, o.addr}, {e.wr, e.addr}); end
            end
            @(posedge clk);
            #1;
            if (c == 2) d_read = 1'b0;
        end
    endtask

    task automatic test_stray_resp();
        logic [3:0] ex;
        txn_t e, o;
        bit ok;
        do_reset();
        mem_auto = 1'b0; man_resp = 1'b1; man_rdata = '1;
        @(negedge clk);
        checks++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
            begin failures++; $display("FAIL stray_resp got=%b exp=0000", {pmem_read, pmem_write, i_resp, d_resp}); end
        @(posedge clk);
        #1;
        man_resp = 1'b0;
        mem_auto = 1'b1; mem_lat = 1; mem_line = {8{32'h1357_9BDF}};
        i_read = 1'b1; i_address = 32'h7000;
        exp_q.push_back(txn_t'{src: 1'b0, wr: 1'b0, addr: 32'h7000, wdata: '0});
        // Command one cycle after the request proves the arbiter stayed in IDLE.
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            ex = {(c == 1), 1'b0, (c == 1), 1'b0};
            checks++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== ex)
                begin failures++; $display("FAIL stray_then_i c=%0d got=%b exp=%b", c, {pmem_read, pmem_write, i_resp, d_resp}, ex); end
            if (i_resp) begin
                pop_sb(e, o, ok);
                checks++;
                if (!ok || {d_resp, o.addr} !== {e.src, e.addr} || i_rdata !== mem_line)
                    begin failures++; $display("FAIL stray_sb ok=%0d got=%h exp=%h", ok, {d_resp, o.addr}, {e.src, e.addr}); end
            end
            @(posedge clk);
            #1;
            if (c == 1) i_read = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_wdata = '0;
        mem_auto = 1'b1; mem_lat = 1; mem_line = '0;
        man_resp = 1'b0; man_rdata = '0;
        test_reset();
        test_single_i();
        test_single_dwrite();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_stray_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
